// File: rtl/dram_bist_seq.sv
// dram_bist_seq: DRAM BIST sequencer that writes a pattern block, reads it back with bounded outstanding reads, and checks it.
// Ports: clk/rst (async, active-high); start/mode/base_addr/num_words launch a test;
//        req_* is the master_fifo request channel, rsp_* the in-order read response channel;
//        busy/done/pass/err_count/first_err_addr/led report status.
module dram_bist_seq #(
    parameter int          ADDR_W          = 27,
    parameter int          DATA_W          = 128,
    parameter int          CNT_W           = 16,
    parameter int          ADDR_STEP       = 8,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] LFSR_SEED       = 32'h1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              req_cmd,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    output logic              req_en,
    input  logic              req_rdy,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_en,
    output logic              rsp_rdy,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              led
);
    localparam logic [31:0] POLY = 32'h80200003;
    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RSP, FINISH} state_t;
    state_t            state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q, raddr, addr_next;
    logic [CNT_W-1:0]  n_q, k, j, err_next;
    logic [31:0]       lfsr, rlfsr;
    logic [3:0]        osd, osd_next;
    logic              acc, rsp_ok, mism, last;

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ POLY : s >> 1;
    endfunction

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                              input logic [CNT_W-1:0] idx, input logic [31:0] l);
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W / 32; i++)
            p[32*i +: 32] = (m == 2'd2) ? l : (m == 2'd3) ? ~(32'(a) + 32'(i)) : 32'(a) + 32'(i);
        return (m == 2'd1) ? DATA_W'(1) << (32'(idx) % DATA_W) : p;
    endfunction

    assign rsp_rdy = 1'b1;
    assign led     = pass;

    // The write side and the compare side each run their own pattern generator (k/lfsr vs j/raddr/rlfsr).
    always_comb begin
        acc       = req_en && req_rdy;
        rsp_ok    = rsp_en && busy;
        mism      = rsp_ok && (rsp_data != pat(mode_q, raddr, j, rlfsr));
        err_next  = (mism && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
        osd_next  = osd + {3'b0, acc && req_cmd} - {3'b0, rsp_ok && osd != 4'd0};
        last      = (k == n_q - CNT_W'(1));
        addr_next = req_addr + ADDR_W'(ADDR_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mode_q         <= '0;
            base_q         <= '0;
            n_q            <= '0;
            k              <= '0;
            j              <= '0;
            raddr          <= '0;
            lfsr           <= LFSR_SEED;
            rlfsr          <= LFSR_SEED;
            osd            <= '0;
            req_en         <= 1'b0;
            req_cmd        <= 1'b0;
            req_addr       <= '0;
            req_data       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            osd  <= osd_next;
            if (rsp_ok) begin
                j         <= j + CNT_W'(1);
                raddr     <= raddr + ADDR_W'(ADDR_STEP);
                rlfsr     <= lstep(rlfsr);
                err_count <= err_next;
                if (mism && err_count == '0)
                    first_err_addr <= raddr;
            end
            case (state)
                IDLE: if (start) begin
                    mode_q         <= mode;
                    base_q         <= base_addr;
                    n_q            <= num_words;
                    k              <= '0;
                    j              <= '0;
                    raddr          <= base_addr;
                    lfsr           <= LFSR_SEED;
                    rlfsr          <= LFSR_SEED;
                    osd            <= '0;
                    busy           <= 1'b1;
                    pass           <= 1'b0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    req_cmd        <= 1'b0;
                    req_addr       <= base_addr;
                    req_data       <= pat(mode, base_addr, '0, LFSR_SEED);
                    req_en         <= num_words != '0;
                    state          <= (num_words == '0) ? FINISH : WRITE;
                end
                WRITE: if (acc) begin
                    if (last) begin
                        k        <= '0;
                        req_cmd  <= 1'b1;
                        req_addr <= base_q;
                        req_data <= '0;
                        state    <= READ;
                    end else begin
                        k        <= k + CNT_W'(1);
                        lfsr     <= lstep(lfsr);
                        req_addr <= addr_next;
                        req_data <= pat(mode_q, addr_next, k + CNT_W'(1), lstep(lfsr));
                    end
                end
                READ: begin
                    if (acc && last) begin
                        req_en <= 1'b0;
                        state  <= WAIT_RSP;
                    end else begin
                        if (acc) begin
                            k        <= k + CNT_W'(1);
                            req_addr <= addr_next;
                        end
                        req_en <= osd_next < 4'(MAX_OUTSTANDING);
                    end
                end
                WAIT_RSP: if (j == n_q) state <= FINISH;
                FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    pass     <= err_next == '0;
                    req_cmd  <= 1'b0;
                    req_addr <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
